// File: rtl/issue_queue.sv
// In-order issue queue: circular buffer between decode/issue and execute, with
// misprediction flush and a saturating count of cycles spent full.
module issue_queue #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enq_valid,
  input  logic [DATA_W-1:0]          enq_data,
  input  logic                       deq_ready,
  output logic                       deq_valid,
  output logic [DATA_W-1:0]          deq_data,
  input  logic                       branch_miss,
  output logic                       issue_queue_full,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic [CNT_W-1:0]           full_cycles
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CNT_W-1:0]  r_full_cycles;

  logic              w_empty;
  logic              w_full;
  logic              w_enq_fire;
  logic              w_deq_fire;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty    = (r_head == r_tail);
  assign w_full     = (r_head[IW-1:0] == r_tail[IW-1:0]) && (r_head[IW] != r_tail[IW]);
  assign w_enq_fire = enq_valid && !w_full && !branch_miss;
  assign w_deq_fire = !w_empty && deq_ready && !branch_miss;

  assign deq_valid        = !w_empty;
  assign deq_data         = r_mem[r_head[IW-1:0]];
  assign issue_queue_full = w_full;
  assign occupancy        = r_tail - r_head;
  assign full_cycles      = r_full_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (branch_miss) begin
      r_head <= r_tail;
    end else begin
      if (w_enq_fire) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_deq_fire) begin
        r_head <= r_head + PW'(1);
      end
    end
  end

  // Storage has no reset; only entries between head and tail are ever observed.
  always_ff @(posedge clk) begin
    if (w_enq_fire && !rst) begin
      r_mem[r_tail[IW-1:0]] <= enq_data;
    end
  end

  // Counts full cycles, including a cycle in which a flush occurs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_full_cycles <= '0;
    end else if (w_full && (r_full_cycles != {CNT_W{1'b1}})) begin
      r_full_cycles <= r_full_cycles + CNT_W'(1);
    end else begin
      r_full_cycles <= r_full_cycles;
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Directed plus randomized bench for issue_queue, checked against a queue-based
// reference model; a narrow counter width lets saturation be reached.
module tb_issue_queue;

  localparam int DEPTH  = 8;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 4;
  localparam int OW     = $clog2(DEPTH) + 1;
  localparam int FC_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              enq_valid;
  logic [DATA_W-1:0] enq_data;
  logic              deq_ready;
  logic              deq_valid;
  logic [DATA_W-1:0] deq_data;
  logic              branch_miss;
  logic              issue_queue_full;
  logic [OW-1:0]     occupancy;
  logic [CNT_W-1:0]  full_cycles;

  logic [DATA_W-1:0] mq [$];
  int                m_fc;
  int                prev_fc;
  bit                last_rst;
  int                vectors;
  int                miscompares;

  always #5 clk = ~clk;

  issue_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .enq_valid        (enq_valid),
    .enq_data         (enq_data),
    .deq_ready        (deq_ready),
    .deq_valid        (deq_valid),
    .deq_data         (deq_data),
    .branch_miss      (branch_miss),
    .issue_queue_full (issue_queue_full),
    .occupancy        (occupancy),
    .full_cycles      (full_cycles)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("deq_valid", 64'(deq_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) chk("deq_data", deq_data, mq[0]);
    chk("occupancy", 64'(occupancy), 64'(mq.size()));
    chk("full", 64'(issue_queue_full), 64'(mq.size() == DEPTH));
    chk("full_cycles", 64'(full_cycles), 64'(m_fc));
    chk("occ_bound", 64'(occupancy <= OW'(DEPTH)), 64'(1));
    if (!last_rst) chk("fc_monotonic", 64'(int'(full_cycles) >= prev_fc), 64'(1));
    prev_fc = int'(full_cycles);
  endtask

  // Apply current inputs for one clock, advance the model, then compare.
  task automatic step();
    bit was_full;
    bit d;
    bit e;
    was_full = (mq.size() == DEPTH);
    last_rst = rst;
    if (rst) begin
      mq.delete();
      m_fc = 0;
    end else begin
      if (was_full && m_fc < FC_MAX) m_fc++;
      if (branch_miss) begin
        mq.delete();
      end else begin
        d = deq_ready && (mq.size() > 0);
        e = enq_valid && (mq.size() < DEPTH);
        if (d) void'(mq.pop_front());
        if (e) mq.push_back(enq_data);
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input bit ev, input logic [DATA_W-1:0] ed, input bit dr, input bit bm);
    enq_valid   = ev;
    enq_data    = ed;
    deq_ready   = dr;
    branch_miss = bm;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    prev_fc     = 0;
    m_fc        = 0;

    // T1: reset held two cycles with enq_valid asserted
    rst = 1'b1;
    drive(1'b1, 64'h55, 1'b0, 1'b0);
    step();
    step();
    chk("t1_occ", 64'(occupancy), 64'd0);
    chk("t1_fc", 64'(full_cycles), 64'd0);
    rst = 1'b0;

    // T2: fill with 1..9, nothing dequeued; 9 must be refused
    for (int i = 1; i <= 9; i++) begin
      drive(1'b1, 64'(i), 1'b0, 1'b0);
      step();
    end
    chk("t2_occ", 64'(occupancy), 64'd8);
    chk("t2_full", 64'(issue_queue_full), 64'd1);
    chk("t2_fc", 64'(full_cycles), 64'd1);
    step();
    step();
    chk("t2_fc_hold", 64'(full_cycles), 64'd3);

    // T3: drain in order
    for (int i = 1; i <= 8; i++) begin
      chk("t3_order", deq_data, 64'(i));
      drive(1'b0, 64'h0, 1'b1, 1'b0);
      step();
      if (i == 1) chk("t3_full_drop", 64'(issue_queue_full), 64'd0);
    end
    chk("t3_empty", 64'(deq_valid), 64'd0);

    // T4: occupancy 3, then 20 simultaneous enq/deq cycles
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'(16'hA0 + i), 1'b0, 1'b0);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, {$urandom, $urandom}, 1'b1, 1'b0);
      step();
    end
    chk("t4_occ", 64'(occupancy), 64'd3);

    // T5: reach occupancy 5, then flush with enq and deq requested
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
      step();
    end
    chk("t5_pre_occ", 64'(occupancy), 64'd5);
    drive(1'b1, 64'hDEAD, 1'b1, 1'b1);
    step();
    chk("t5_occ", 64'(occupancy), 64'd0);
    chk("t5_valid", 64'(deq_valid), 64'd0);

    // T6: full queue with enq and deq together, then enq alone
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, {$urandom, $urandom}, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 64'hBEEF, 1'b1, 1'b0);
    step();
    chk("t6_occ7", 64'(occupancy), 64'd7);
    drive(1'b1, 64'hBEEF, 1'b0, 1'b0);
    step();
    chk("t6_occ8", 64'(occupancy), 64'd8);

    // Hold full long enough for the counter to saturate
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step();
    chk("sat_fc", 64'(full_cycles), 64'(FC_MAX));
    drive(1'b0, 64'h0, 1'b0, 1'b1);
    step();
    chk("flush_from_full", 64'(occupancy), 64'd0);

    // Randomized traffic with occasional flushes and resets
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3) != 0, {$urandom, $urandom},
            $urandom_range(0, 2) == 0, $urandom_range(0, 39) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
